seq_pattern_gen: RTL and testbench

//   Serial bit-pattern transmitter: loads a programmable pattern of up to W bits and emits it MSB-first on a 1-bit serial line.
//   It is the driving end of the serial pattern interface consumed by the team's sequence detectors (e.g. the "110" detector).

---
 rtl/seq_pkg.sv | 15 +
 rtl/seq_pattern_shifter.sv | 52 +++++
 rtl/seq_pattern_gen.sv | 144 ++++++++++++++
 tb/tb_seq_pattern_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - state encoding and default widths for the serial pattern generator
package seq_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_REP_W = 4;
  localparam int DEF_GAP_W = 4;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SHIFT = 3'd1;
  localparam logic [2:0] GAP   = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

endpackage

// File: rtl/seq_pattern_shifter.sv
// rtl/seq_pattern_shifter.sv - pattern store, MSB-first bit index and running even parity
module seq_pattern_shifter #(
  parameter int W     = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             restart,
  input  logic             shift,
  input  logic [W-1:0]     pat_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             bit_out,
  output logic             last,
  output logic             parity
);

  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]     pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic             par_q;

  // restart replays the stored pattern for the next repetition
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      par_q <= 1'b0;
    end else if (load) begin
      pat_q <= pat_i;
      len_q <= len_i;
      idx_q <= len_i - LEN_W'(1);
      par_q <= 1'b0;
    end else if (restart) begin
      idx_q <= len_q - LEN_W'(1);
      par_q <= 1'b0;
    end else if (shift) begin
      if (!last) begin
        idx_q <= idx_q - LEN_W'(1);
      end
      par_q <= par_q ^ bit_out;
    end
  end

  assign bit_out = pat_q[idx_q[IDX_W-1:0]];
  assign last    = (idx_q == '0);
  assign parity  = par_q;

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial MSB-first pattern transmitter with repeat count and idle gap
// Optional per-instance even parity bit: define SEQ_PATTERN_GEN_PARITY_EN
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int REP_W = DEF_REP_W,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [W-1:0]     pat,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] W_LEN = LEN_W'(W);

  logic [2:0]       state_q, state_d;
  logic [2:0]       next_inst;
  logic [REP_W-1:0] rep_left_q;
  logic [GAP_W-1:0] gap_q, gap_cnt_q;
  logic [LEN_W-1:0] len_sat;
  logic             accept, inst_end, restart;
  logic             sh_bit, sh_last, sh_parity;

  assign len_sat = (pat_len > W_LEN) ? W_LEN : pat_len;
  assign accept  = start_valid && (state_q == IDLE) && !abort;

`ifdef SEQ_PATTERN_GEN_PARITY_EN
  assign inst_end = (state_q == PAR);
`else
  assign inst_end = (state_q == SHIFT) && sh_last;
  logic unused_parity;
  assign unused_parity = sh_parity;
`endif

  assign restart = (state_d == SHIFT) && ((state_q == GAP) || inst_end);

  seq_pattern_shifter #(
    .W     (W),
    .LEN_W (LEN_W)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .restart (restart),
    .shift   (state_q == SHIFT),
    .pat_i   (pat),
    .len_i   (len_sat),
    .bit_out (sh_bit),
    .last    (sh_last),
    .parity  (sh_parity)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    next_inst = DONE;
    if (rep_left_q != '0) begin
      next_inst = (gap_q != '0) ? GAP : SHIFT;
    end
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = (len_sat == '0) ? DONE : SHIFT;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      SHIFT: if (sh_last) state_d = PAR;
      PAR:   state_d = next_inst;
`else
      SHIFT: if (sh_last) state_d = next_inst;
`endif
      GAP:   if (gap_cnt_q == GAP_W'(1)) state_d = SHIFT;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    x           = 1'b0;
    x_valid     = 1'b0;
    done        = 1'b0;
    busy        = 1'b0;
    start_ready = 1'b0;
    case (state_q)
      IDLE:  start_ready = 1'b1;
      SHIFT: begin
        x       = sh_bit;
        x_valid = 1'b1;
        busy    = 1'b1;
      end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      PAR: begin
        x       = sh_parity;
        x_valid = 1'b1;
        busy    = 1'b1;
      end
`endif
      GAP:   busy = 1'b1;
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // rep_left_q counts instances still owed after the current one
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_left_q <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
    end else if (accept) begin
      rep_left_q <= (reps == '0) ? '0 : reps - REP_W'(1);
      gap_q      <= gap;
      gap_cnt_q  <= '0;
    end else begin
      if (inst_end && (rep_left_q != '0)) begin
        rep_left_q <= rep_left_q - REP_W'(1);
      end
      if ((state_d == GAP) && (state_q != GAP)) begin
        gap_cnt_q <= gap_q;
      end else if (state_q == GAP) begin
        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - directed bench for seq_pattern_gen (expectations follow SEQ_PATTERN_GEN_PARITY_EN)
module tb_seq_pattern_gen;

  logic       clk;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] pat;
  logic [3:0] pat_len;
  logic [3:0] reps;
  logic [3:0] gap;
  logic       abort;
  logic       x;
  logic       x_valid;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] cap_v;
  logic [63:0] cap_x;
  int          cap_done;
  int          det_hits;

  seq_pattern_gen dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .pat         (pat),
    .pat_len     (pat_len),
    .reps        (reps),
    .gap         (gap),
    .abort       (abort),
    .x           (x),
    .x_valid     (x_valid),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_req(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                           input logic [3:0] g);
    @(negedge clk);
    pat         = p;
    pat_len     = l;
    reps        = r;
    gap         = g;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    pat         = 8'h00;
    pat_len     = 4'd0;
    reps        = 4'd0;
    gap         = 4'd0;
  endtask

  // Records the stream until done; also runs a small "110" detector on valid bits.
  task automatic capture();
    logic [2:0] sh;
    int         nbits;
    cap_v    = '0;
    cap_x    = '0;
    cap_done = -1;
    det_hits = 0;
    sh       = 3'b000;
    nbits    = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (done) begin
        cap_done = k;
        break;
      end
      cap_v = {cap_v[62:0], x_valid};
      cap_x = {cap_x[62:0], x};
      if (x_valid) begin
        sh = {sh[1:0], x};
        nbits++;
        if (nbits >= 3 && sh == 3'b110) det_hits++;
      end
    end
  endtask

  task automatic run(input string tag, input logic [7:0] p, input logic [3:0] l,
                     input logic [3:0] r, input logic [3:0] g, input logic [63:0] exp_v,
                     input logic [63:0] exp_x, input int exp_done);
    start_req(p, l, r, g);
    capture();
    check_eq({tag, "_valid"}, cap_v, exp_v);
    check_eq({tag, "_bits"}, cap_x, exp_x);
    check_eq({tag, "_done_cycle"}, 64'(cap_done), 64'(exp_done));
  endtask

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    pat         = 8'h00;
    pat_len     = 4'd0;
    reps        = 4'd0;
    gap         = 4'd0;
    abort       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", {x, x_valid, busy, done, start_ready}, 5'b00001);
    rst = 1'b0;

    // 110 once: bits on cycles 1-3, done on 4, ready on 5
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    run("t1", 8'b110, 4'd3, 4'd1, 4'd0, 64'b1111, 64'b1100, 5);
`else
    run("t1", 8'b110, 4'd3, 4'd1, 4'd0, 64'b111, 64'b110, 4);
`endif
    check_eq("t1_ready_in_done", start_ready, 1'b0);
    @(negedge clk);
    check_eq("t1_ready_after", start_ready, 1'b1);

    // 110 twice with a 2-cycle gap
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    run("t2", 8'b110, 4'd3, 4'd2, 4'd2, 64'b1111001111, 64'b1100001100, 11);
`else
    run("t2", 8'b110, 4'd3, 4'd2, 4'd2, 64'b11100111, 64'b11000110, 9);
`endif
    check_eq("t2_detector_hits", 64'(det_hits), 64'd2);

    run("t3_len0", 8'hFF, 4'd0, 4'd3, 4'd1, 64'b0, 64'b0, 1);

    // reps=15 back-to-back single-bit instances, no wrap of the repeat counter
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    run("reps15", 8'h01, 4'd1, 4'd15, 4'd0, {34'b0, {30{1'b1}}}, {34'b0, {30{1'b1}}}, 31);
`else
    run("reps15", 8'h01, 4'd1, 4'd15, 4'd0, {49'b0, {15{1'b1}}}, {49'b0, {15{1'b1}}}, 16);
`endif

    // pat_len 12 saturates to 8
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    run("len_sat", 8'b1000_0001, 4'd12, 4'd1, 4'd0, 64'h1FF, 64'b100000010, 10);
`else
    run("len_sat", 8'b1000_0001, 4'd12, 4'd1, 4'd0, 64'hFF, 64'b10000001, 9);
`endif

`ifdef SEQ_PATTERN_GEN_PARITY_EN
    run("t6_parity", 8'b1011, 4'd4, 4'd1, 4'd0, 64'b11111, 64'b10111, 6);
`endif

    // abort on the second bit of an 8-bit transfer
    @(negedge clk);
    start_req(8'hA5, 4'd8, 4'd1, 4'd0);
    @(negedge clk);
    check_eq("t4_bit1", {x_valid, x}, 2'b11);
    @(negedge clk);
    check_eq("t4_bit2", {x_valid, x}, 2'b10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t4_after_abort", {x_valid, busy, done, start_ready}, 4'b0001);
    @(negedge clk);
    check_eq("t4_no_done", {done, busy}, 2'b00);

    // abort beats a request while idle
    start_valid = 1'b1;
    abort       = 1'b1;
    pat_len     = 4'd3;
    pat         = 8'b110;
    @(negedge clk);
    start_valid = 1'b0;
    abort       = 1'b0;
    check_eq("idle_abort_wins", {busy, x_valid, start_ready}, 3'b001);
    @(negedge clk);
    check_eq("idle_abort_still", {busy, x_valid}, 2'b00);

    // reset while in the gap
    start_req(8'b110, 4'd3, 4'd2, 4'd2);
    begin
      logic found;
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (busy && !x_valid) begin
          found = 1'b1;
          break;
        end
      end
      check_eq("t5_reached_gap", found, 1'b1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_reset_outputs", {x, x_valid, busy, done, start_ready}, 5'b00001);
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    run("t5_resume", 8'b110, 4'd3, 4'd1, 4'd0, 64'b1111, 64'b1100, 5);
`else
    run("t5_resume", 8'b110, 4'd3, 4'd1, 4'd0, 64'b111, 64'b110, 4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
